// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data requesters.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic                    dm_gnt,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    fetch_stall,
  output logic                    dm_stall
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   win_dm;
  logic   route_dm;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             force_if;

  assign force_if = if_req && (starve_q == CNT_W'(STARVE_LIMIT));
  assign win_dm   = dm_req && !force_if;

  // Counts IDLE arbitrations that fetch lost while it was waiting.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (state_q == IDLE && win_dm) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign win_dm = dm_req && (STARVE_LIMIT >= 0);
`endif

  assign route_dm = (state_q == IDLE) ? win_dm : owner_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          mem_req = 1'b1;
          owner_d = win_dm;
          if (mem_ready) begin
            if_gnt  = !win_dm;
            dm_gnt  = win_dm;
            state_d = WAIT_RESP;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          if_gnt  = !owner_q;
          dm_gnt  = owner_q;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) begin
          if (owner_q) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_req) begin
      if (route_dm) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_be    = dm_be;
      end else begin
        mem_addr  = if_addr;
        mem_be    = {BE_W{1'b1}};
      end
    end

    fetch_stall = if_req && !if_rvalid;
    dm_stall    = dm_req && !dm_rvalid;

    // Outputs are forced quiet for the whole reset cycle, whatever state was left behind.
    if (rst) begin
      if_gnt      = 1'b0;
      dm_gnt      = 1'b0;
      if_rvalid   = 1'b0;
      dm_rvalid   = 1'b0;
      if_rdata    = '0;
      dm_rdata    = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_be      = '0;
      fetch_stall = 1'b0;
      dm_stall    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fetch_stall, dm_stall;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall), .dm_stall(dm_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ctl = {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, fetch_stall, dm_stall}
  function automatic logic [63:0] ctl();
    return {52'd0, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, fetch_stall, dm_stall};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".ctl"}, ctl(), 64'd0);
    check({tag, ".rdata"}, {if_rdata, dm_rdata}, 64'd0);
    check({tag, ".mem"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  int dm_grants;
  bit got_if;

  initial begin
    idle_inputs();
    rst = 1;
    // Reset cycle with live requests still yields quiet outputs.
    if_req = 1; if_addr = 32'h100; dm_req = 1; mem_ready = 1;
    settle();
    check_quiet("reset_cycle");
    tick();
    idle_inputs();
    tick();
    rst = 0;
    settle();
    check_quiet("after_reset");

    // Single fetch
    tick();
    if_req = 1; if_addr = 32'h100; mem_ready = 1;
    settle();
    check("f1.if_gnt", if_gnt, 1);
    check("f1.mem_addr", mem_addr, 32'h100);
    check("f1.mem_be_we", {mem_be, mem_we, mem_req}, {4'hF, 1'b0, 1'b1});
    check("f1.stall", {fetch_stall, dm_stall, dm_gnt}, 3'b100);
    tick();
    mem_ready = 0; mem_rdata = 32'h12345678;
    settle();
    check("f1.wait", {mem_req, if_gnt, if_rvalid, fetch_stall}, 4'b0001);
    check("f1.rdata_gated", if_rdata, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    settle();
    check("f1.rvalid", {if_rvalid, dm_rvalid, fetch_stall}, 3'b100);
    check("f1.if_rdata", {if_rdata, dm_rdata}, {32'h00500093, 32'd0});
    tick();
    idle_inputs();
    settle();
    check_quiet("f1.done");

    // Simultaneous requests: data first, fetch one cycle after dm_rvalid
    tick();
    if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h2000; mem_ready = 1;
    settle();
    check("sim.grant", {dm_gnt, if_gnt, fetch_stall}, 3'b101);
    check("sim.mem_addr", mem_addr, 32'h2000);
    tick();
    mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    settle();
    check("sim.dm_rvalid", {dm_rvalid, if_rvalid, if_gnt, fetch_stall, dm_stall}, 5'b10010);
    check("sim.dm_rdata", dm_rdata, 32'hAAAA5555);
    tick();
    dm_req = 0; mem_rvalid = 0;
    settle();
    check("sim.if_grant", {if_gnt, dm_gnt, fetch_stall}, 3'b101);
    check("sim.if_addr", mem_addr, 32'h104);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h13;
    settle();
    check("sim.if_rvalid", {if_rvalid, if_rdata}, {1'b1, 32'h13});
    tick();
    idle_inputs();

    // HOLD lock: fetch owns the port while data arrives
    tick();
    if_req = 1; if_addr = 32'h200; mem_ready = 0;
    settle();
    check("hold.c0", {mem_req, if_gnt, mem_addr}, {1'b1, 1'b0, 32'h200});
    tick();
    dm_req = 1; dm_addr = 32'h2040;
    settle();
    check("hold.c1", {mem_req, if_gnt, dm_gnt, mem_addr}, {3'b100, 32'h200});
    tick();
    settle();
    check("hold.c2", {if_gnt, dm_gnt, mem_addr}, {2'b00, 32'h200});
    tick();
    mem_ready = 1;
    settle();
    check("hold.c3", {if_gnt, dm_gnt, mem_addr}, {2'b10, 32'h200});
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    settle();
    check("hold.if_rvalid", {if_rvalid, dm_rvalid, dm_stall}, 3'b101);
    tick();
    if_req = 0; mem_rvalid = 0; mem_ready = 1;
    settle();
    check("hold.dm_grant", {dm_gnt, if_gnt, mem_addr}, {2'b10, 32'h2040});
    tick();
    mem_rvalid = 1; mem_rdata = 32'h4444;
    settle();
    check("hold.dm_rvalid", {dm_rvalid, dm_rdata}, {1'b1, 32'h4444});
    tick();
    idle_inputs();

    // Store
    tick();
    dm_req = 1; dm_we = 1; dm_addr = 32'h3004; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011; mem_ready = 1;
    settle();
    check("st.grant", {dm_gnt, mem_we, mem_be}, {1'b1, 1'b1, 4'b0011});
    check("st.fields", {mem_addr, mem_wdata}, {32'h3004, 32'hDEADBEEF});
    tick();
    mem_ready = 0;
    settle();
    check("st.wait_zero", {mem_req, mem_we, mem_be, mem_wdata}, 38'd0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'd0;
    settle();
    check("st.ack", {dm_rvalid, dm_rdata, dm_stall}, {1'b1, 32'd0, 1'b0});
    tick();
    idle_inputs();

    // Reset while awaiting a response
    tick();
    if_req = 1; if_addr = 32'h300; mem_ready = 1;
    settle();
    check("rst.grant", if_gnt, 1);
    tick();
    rst = 1; if_req = 0; mem_ready = 0;
    settle();
    check_quiet("rst.during");
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    settle();
    check_quiet("rst.late_rvalid");
    tick();
    mem_rvalid = 0; dm_req = 1; dm_addr = 32'h2100; mem_ready = 1;
    settle();
    check("rst.new_grant", {dm_gnt, mem_addr}, {1'b1, 32'h2100});
    tick();
    mem_rvalid = 1; mem_rdata = 32'h88;
    settle();
    check("rst.new_rvalid", {dm_rvalid, dm_rdata}, {1'b1, 32'h88});
    tick();
    idle_inputs();

    // Fetch held against back-to-back loads (5 loads then data drops)
    tick();
    if_req = 1; if_addr = 32'h400; dm_req = 1; dm_addr = 32'h2200;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h99;
    dm_grants = 0; got_if = 0;
    settle();
    for (int c = 0; c < 40 && !got_if; c++) begin
      if (if_gnt) got_if = 1;
      if (dm_gnt) dm_grants++;
      if (if_gnt && dm_gnt) check("starve.excl", 1, 0);
      if (dm_rvalid && dm_grants >= 5) begin
        tick();
        dm_req = 0;
        settle();
      end else if (!got_if) begin
        tick();
      end
    end
    check("starve.if_granted", got_if, 1);
`ifdef ARB_STARVE_GUARD_EN
    check("starve.dm_grants", dm_grants, 4);
`else
    check("starve.dm_grants", dm_grants, 5);
`endif
    tick();
    settle();
    check("starve.if_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory-access stage (loads/stores) of the 5-stage RISC-V pipeline.
- Sequences one outstanding memory transaction at a time.
- Routes each response back to the requester that owns it.
- Raises per-stage stall outputs so the pipeline flop enables can be held while a requester waits.

Parameters:
ADDR_WIDTH, 32, memory byte-address width
DATA_WIDTH, 32, memory data width
STARVE_LIMIT, 4, consecutive lost arbitrations before fetch is forced to win (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch read request; held until if_gnt
if_addr  input  ADDR_WIDTH  fetch address
if_gnt  output  1  fetch request accepted by memory
if_rvalid  output  1  fetch read data valid
if_rdata  output  DATA_WIDTH  fetch read data
dm_req  input  1  data request (load or store); held until dm_gnt
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_WIDTH  data address
dm_wdata  input  DATA_WIDTH  store data
dm_be  input  DATA_WIDTH/8  store byte enables
dm_gnt  output  1  data request accepted by memory
dm_rvalid  output  1  load data valid / store complete
dm_rdata  output  DATA_WIDTH  load data
mem_req  output  1  request to memory
mem_we  output  1  write strobe to memory
mem_addr  output  ADDR_WIDTH  address to memory
mem_wdata  output  DATA_WIDTH  write data to memory
mem_be  output  DATA_WIDTH/8  byte enables to memory
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  memory response valid (reads and writes)
mem_rdata  input  DATA_WIDTH  memory read data
fetch_stall  output  1  if_req && !if_rvalid
dm_stall  output  1  dm_req && !dm_rvalid

Behaviour:
- FSM states: IDLE, HOLD, WAIT_RESP. A 1-bit owner register records the winner (0 = fetch, 1 = data).
- Reset: state = IDLE, owner = 0, starvation counter = 0.
  - All outputs 0 in the reset cycle and after reset, until a new request.
  - mem_addr, mem_wdata, mem_be and mem_we are driven 0 whenever mem_req = 0.
- IDLE:
  - If any request is present, select the winner combinationally. Data wins when both request (subject to the optional feature).
  - Drive mem_req and the winner's fields in the same cycle as the request (zero-cycle arbitration); the fetch path drives mem_we = 0 and mem_be = all ones.
  - If mem_ready = 1: pulse the winner's gnt, latch owner, go to WAIT_RESP.
  - If mem_ready = 0: latch owner, go to HOLD.
- HOLD:
  - Owner is locked; the other requester cannot preempt even if it has higher priority.
  - Keep mem_req = 1 with the owner's live request fields.
  - On mem_ready, pulse the owner's gnt and go to WAIT_RESP.
- WAIT_RESP:
  - mem_req = 0.
  - On mem_rvalid, pulse the owner's rvalid for 1 cycle, pass mem_rdata to the owner's rdata, and go to IDLE.
  - The next arbitration happens the following cycle, so the minimum spacing between grants is 2 cycles.
- Response routing:
  - mem_rvalid is ignored in IDLE and HOLD; no requester rvalid is asserted.
  - rdata outputs are 0 except in their rvalid cycle.
- Requester rules: req and its fields stay stable from assertion until gnt, and req drops in the cycle after rvalid or later. The arbiter does not check these rules.
- Stalls: fetch_stall and dm_stall are combinational, per the port definitions. They stay 1 through HOLD and WAIT_RESP and go to 0 in the rvalid cycle.
- rst during HOLD or WAIT_RESP: the transaction is abandoned, the FSM returns to IDLE, and a late mem_rvalid after reset is ignored.
- Only one of if_gnt / dm_gnt is ever asserted in a cycle; the same holds for if_rvalid / dm_rvalid.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - Counter width is $clog2(STARVE_LIMIT+1).
  - The counter increments on each IDLE cycle where if_req = 1 and data wins.
  - It clears on if_gnt, or on any cycle with if_req = 0.
  - When the counter equals STARVE_LIMIT and both requesters request in IDLE, fetch wins.
- Not defined: strict data priority; no counter logic is synthesized.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x100, mem_ready = 1; mem_rvalid 2 cycles later with rdata 0x00500093 -> if_gnt in cycle 0, if_rvalid = 1 with if_rdata = 0x00500093 exactly in the response cycle; fetch_stall high until then; dm_* outputs stay 0.
- Simultaneous requests: if_req and dm_req (load, 0x2000) both in the same cycle -> mem_addr = 0x2000 and dm_gnt first; fetch is granted only after dm_rvalid plus 1 cycle; fetch_stall stays 1 throughout.
- HOLD lock: fetch alone requests with mem_ready = 0 for 3 cycles; dm_req rises in cycle 1 -> mem_addr stays equal to if_addr, if_gnt on the cycle mem_ready = 1, data served afterwards.
- Store: dm_we = 1, addr 0x3004, wdata 0xDEADBEEF, be 4'b0011 -> mem_we = 1 and mem_be = 4'b0011 in the grant cycle; dm_rvalid on the write ack; dm_rdata = 0.
- Reset mid-WAIT_RESP: rst pulsed while awaiting a response, then mem_rvalid the next cycle -> no if_rvalid or dm_rvalid, all outputs 0, and a new request is granted normally.
- Starvation (macro defined, STARVE_LIMIT = 4): if_req held while dm_req issues back-to-back loads -> fetch wins at the 5th contended IDLE cycle; without the macro, fetch waits until dm_req drops.
